pipeline_ctrl: RTL and testbench

Central pipeline controller for the five-stage RISC-V core. It merges per-stage stall requests into the `stall[5:0]` vector consumed by every pipeline register (`pc_reg`, `if_id`, `id_ex`, `ex_mem`, `mem_wb`). It also sequences trap entry and `mret` return: it raises a one-cycle `flush` and supplies `new_pc`. If a Wishbone transaction is still in flight, it first waits for that transaction to finish.

---
 rtl/pipeline_ctrl_pkg.sv | 30 +++
 rtl/pipeline_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: exception codes, stall vectors,
// FSM state type and the trap target selection helper.
package pipeline_ctrl_pkg;

  localparam int REG_W = 32;

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_ECALL   = 32'h8;
  localparam logic [31:0] EXC_ILLEGAL = 32'ha;
  localparam logic [31:0] EXC_MRET    = 32'he;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_BUS = 1'b1
  } state_t;

  // mret returns to mepc; every other non-zero code traps to mtvec.
  function automatic logic [REG_W-1:0] trap_target(input logic [31:0] code,
                                                   input logic [REG_W-1:0] mtvec,
                                                   input logic [REG_W-1:0] mepc);
    return (code == EXC_MRET) ? mepc : mtvec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stall requests and sequences trap entry / mret.
// Optional stall-cycle counter is enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [REG_W-1:0] csr_mtvec_i,
  input  logic [REG_W-1:0] csr_mepc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [REG_W-1:0] new_pc,
  output logic             trap_busy_o
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles_o
`endif
);

  state_t           state_reg;
  logic [REG_W-1:0] pc_q;
  logic             bus_busy;
  logic             has_exc;
  logic [REG_W-1:0] target;

  assign bus_busy = stallreq_from_if | stallreq_from_mem;
  assign has_exc  = (excepttype_i != EXC_NONE);
  assign target   = trap_target(excepttype_i, csr_mtvec_i, csr_mepc_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_q      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (has_exc && bus_busy) begin
            state_reg <= ST_WAIT_BUS;
            pc_q      <= target;
          end
        end
        ST_WAIT_BUS: begin
          if (!bus_busy) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Mealy outputs: a trap with the bus idle redirects in the detection cycle.
  always_comb begin
    stall       = STALL_NONE;
    flush       = 1'b0;
    new_pc      = '0;
    trap_busy_o = 1'b0;
    if (!rst) begin
      if (state_reg == ST_WAIT_BUS) begin
        trap_busy_o = 1'b1;
        if (bus_busy) begin
          stall = STALL_MEM;
        end else begin
          flush  = 1'b1;
          new_pc = pc_q;
        end
      end else if (has_exc) begin
        if (bus_busy) begin
          stall = STALL_MEM;
        end else begin
          flush  = 1'b1;
          new_pc = target;
        end
      end else if (stallreq_from_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_from_ex) begin
        stall = STALL_EX;
      end else if (stallreq_from_id || stallreq_from_if) begin
        stall = STALL_ID;
      end
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (stall[0] && !flush) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, checked against
// a behavioural model built around a "pending trap" record.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
  logic [31:0] excepttype_i, csr_mtvec_i, csr_mepc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        trap_busy_o;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: an outstanding trap waiting for the bus, and its target.
  bit          m_pending = 1'b0;
  logic [31:0] m_pending_pc = '0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .excepttype_i     (excepttype_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .trap_busy_o      (trap_busy_o)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .stall_cycles_o   (stall_cycles_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance model.
  task automatic step(input string tag, input logic r,
                      input logic s_if, input logic s_id, input logic s_ex, input logic s_mem,
                      input logic [31:0] exc, input logic [31:0] mtvec, input logic [31:0] mepc);
    logic [5:0]  e_stall;
    logic        e_flush, e_busy, bus;
    logic [31:0] e_pc, tgt;
    rst = r;
    stallreq_from_if = s_if; stallreq_from_id = s_id;
    stallreq_from_ex = s_ex; stallreq_from_mem = s_mem;
    excepttype_i = exc; csr_mtvec_i = mtvec; csr_mepc_i = mepc;

    bus = s_if | s_mem;
    tgt = (exc == 32'he) ? mepc : mtvec;
    e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'd0; e_busy = 1'b0;
    if (!r) begin
      if (m_pending) begin
        e_busy = 1'b1;
        if (bus) e_stall = 6'b011111;
        else begin e_flush = 1'b1; e_pc = m_pending_pc; end
      end else if (exc != 0) begin
        if (bus) e_stall = 6'b011111;
        else begin e_flush = 1'b1; e_pc = tgt; end
      end else if (s_mem) e_stall = 6'b011111;
      else if (s_ex)      e_stall = 6'b001111;
      else if (s_id || s_if) e_stall = 6'b000111;
    end

    @(negedge clk);
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".new_pc"}, new_pc, e_pc);
    chk({tag, ".trap_busy"}, {31'd0, trap_busy_o}, {31'd0, e_busy});
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk({tag, ".cnt"}, stall_cycles_o, m_cnt);
`endif
    $display("[%0t] %s rst=%0d req(if,id,ex,mem)=%0d%0d%0d%0d exc=%h -> stall=%b flush=%0d new_pc=%h busy=%0d",
             $time, tag, r, s_if, s_id, s_ex, s_mem, exc, stall, flush, new_pc, trap_busy_o);

    @(posedge clk);
    if (r) begin
      m_pending = 1'b0; m_pending_pc = '0; m_cnt = '0;
    end else begin
      if (e_stall[0] && !e_flush) m_cnt = m_cnt + 32'd1;
      if (m_pending) begin
        if (!bus) m_pending = 1'b0;
      end else if (exc != 0 && bus) begin
        m_pending = 1'b1; m_pending_pc = tgt;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] codes [5];
    codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha; codes[3] = 32'he; codes[4] = 32'h33;

    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 1, 1, 1, 1, 32'h8, 32'h100, 32'h200);
    step("idle",   0, 0, 0, 0, 0, 0, 32'h100, 32'h200);

    for (int i = 0; i < 3; i++) step("ex_stall", 0, 0, 0, 1, 0, 0, 32'h100, 32'h200);
    step("ex_done", 0, 0, 0, 0, 0, 0, 32'h100, 32'h200);
    step("mem_id", 0, 0, 1, 0, 1, 0, 32'h100, 32'h200);

    step("ecall", 0, 0, 0, 0, 0, 32'h8, 32'h100, 32'h2004);
    step("post_ecall", 0, 0, 0, 0, 0, 0, 32'h100, 32'h2004);

    step("mret_det", 0, 1, 0, 0, 0, 32'he, 32'h100, 32'h2004);
    step("mret_w1",  0, 1, 0, 0, 0, 32'h8, 32'h100, 32'h0);
    step("mret_w2",  0, 1, 1, 1, 0, 0, 32'h300, 32'h0);
    step("mret_w3",  0, 0, 0, 0, 1, 32'ha, 32'h300, 32'h0);
    step("mret_w4",  0, 1, 0, 0, 0, 0, 32'h300, 32'h0);
    step("mret_fl",  0, 0, 0, 0, 0, 0, 32'h300, 32'h0);
    step("mret_post", 0, 0, 0, 0, 0, 0, 32'h300, 32'h0);
    step("b2b_trap", 0, 0, 0, 0, 0, 32'h1, 32'h440, 32'h0);

    step("rw_det",  0, 0, 0, 0, 1, 32'h8, 32'h500, 32'h0);
    step("rw_wait", 0, 0, 0, 0, 1, 0, 32'h500, 32'h0);
    step("rw_rst",  1, 0, 0, 0, 1, 0, 32'h500, 32'h0);
    step("rw_after", 0, 0, 0, 0, 0, 0, 32'h500, 32'h0);
    step("rw_after2", 0, 0, 0, 0, 0, 0, 32'h500, 32'h0);

    step("cnt_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("id_stall", 0, 0, 1, 0, 0, 0, 0, 0);
    step("id_done", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("cnt_five", stall_cycles_o, 32'd5);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [31:0] exc;
      exc = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 4)] : 32'h0;
      step("rand", ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), exc, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
